// File: rtl/fixed_float_converter.sv
// IEEE-754 single <-> Q2.20 fixed-point converter for the CORDIC datapath.
// Both conversions are combinational and share a single output register stage.
module fixed_float_converter #(
  parameter int FIXED_W = 22,
  parameter int FRAC_W  = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [31:0]        float_in,
  input  logic [FIXED_W-1:0] fixed_in,
  output logic               out_valid,
  output logic [FIXED_W-1:0] fixed_out,
  output logic [31:0]        float_out
);

  localparam int BIAS     = 127;
  localparam int MANT_W   = 23;
  localparam int UFL_EXP  = BIAS - FRAC_W;                 // below this |value| < 2^-FRAC_W
  localparam int SAT_EXP  = BIAS + (FIXED_W - FRAC_W - 1); // at or above this |value| >= 2.0
  localparam int SHIFT_EX = BIAS + MANT_W - FRAC_W;        // right shift = SHIFT_EX - exponent
  localparam int PW       = $clog2(FIXED_W);

  localparam logic [FIXED_W-1:0] POS_MAX = {1'b0, {(FIXED_W-1){1'b1}}};
  localparam logic [FIXED_W-1:0] NEG_MAX = {1'b1, {(FIXED_W-1){1'b0}}};

  // ---------------- float -> fixed ----------------
  logic                 f_sign;
  logic [7:0]           f_exp;
  logic [MANT_W-1:0]    f_mant;
  logic [MANT_W:0]      f_sig;
  logic [7:0]           f_rsh;
  logic [FIXED_W-1:0]   f_mag;
  logic [FIXED_W-1:0]   fixed_next;

  assign f_sign = float_in[31];
  assign f_exp  = float_in[30:23];
  assign f_mant = float_in[22:0];
  assign f_sig  = {1'b1, f_mant};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    f_rsh      = '0;
    f_mag      = '0;
    fixed_next = '0;
    if (f_exp == 8'hFF && f_mant != '0) begin
      fixed_next = '0;
    end else if (f_exp >= 8'(SAT_EXP)) begin
      fixed_next = f_sign ? NEG_MAX : POS_MAX;
    end else if (f_exp >= 8'(UFL_EXP)) begin
      // Truncation toward zero: drop the low significand bits, then negate.
      f_rsh      = 8'(SHIFT_EX) - f_exp;
      f_mag      = FIXED_W'(f_sig >> f_rsh);
      fixed_next = f_sign ? (~f_mag + FIXED_W'(1)) : f_mag;
    end
  end

  // ---------------- fixed -> float ----------------
  logic                 x_sign;
  logic [FIXED_W-1:0]   x_mag;
  logic [MANT_W:0]      x_mag_ext;
  logic [PW-1:0]        x_lead;
  logic [MANT_W-1:0]    x_mant;
  logic [7:0]           x_exp;
  logic [31:0]          float_next;

  assign x_sign    = fixed_in[FIXED_W-1];
  // The most negative code negates to itself, which read unsigned is exactly 2^21.
  assign x_mag     = x_sign ? (~fixed_in + FIXED_W'(1)) : fixed_in;
  assign x_mag_ext = (MANT_W+1)'(x_mag);

  always_comb begin
    x_lead = '0;
    for (int i = 0; i < FIXED_W; i++) begin
      if (x_mag[i]) x_lead = PW'(i);
    end
  end

  always_comb begin
    x_exp      = 8'(UFL_EXP) + 8'(x_lead);
    // The hidden bit lands at position MANT_W and is dropped by the width cast.
    x_mant     = MANT_W'(x_mag_ext << (5'(MANT_W) - 5'(x_lead)));
    float_next = '0;
    if (x_mag != '0) float_next = {x_sign, x_exp, x_mant};
  end

  // ---------------- output register ----------------
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      fixed_out <= '0;
      float_out <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        fixed_out <= fixed_next;
        float_out <= float_next;
      end
    end
  end

endmodule

// File: tb/tb_fixed_float_converter.sv
// Self-checking bench: directed vectors, randomized stimulus against a real-arithmetic
// reference model, reset behaviour and a fixed->float->fixed round-trip stream.
module tb_fixed_float_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] float_in;
  logic [21:0] fixed_in;
  logic        out_valid;
  logic [21:0] fixed_out;
  logic [31:0] float_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [21:0] exp_fixed = '0;
  logic [31:0] exp_float = '0;

  fixed_float_converter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .float_in  (float_in),
    .fixed_in  (fixed_in),
    .out_valid (out_valid),
    .fixed_out (fixed_out),
    .float_out (float_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: value = (-1)^s * 1.m * 2^(e-127), then floor(|v| * 2^20) with saturation.
  function automatic logic [21:0] ref_f2x(input logic [31:0] f);
    int  e   = int'(f[30:23]);
    int  m   = int'(f[22:0]);
    bit  s   = f[31];
    real v;
    int  mag;
    if (e == 255 && m != 0) return 22'h000000;
    if (e == 255) return s ? 22'h200000 : 22'h1FFFFF;
    if (e == 0) return 22'h000000;
    v = (1.0 + real'(m) / 8388608.0) * (2.0 ** real'(e - 127));
    if (v >= 2.0) return s ? 22'h200000 : 22'h1FFFFF;
    mag = $rtoi($floor(v * 1048576.0));
    if (mag == 0) return 22'h000000;
    return s ? 22'(-mag) : 22'(mag);
  endfunction

  // Reference: exact real value of the Q2.20 word, re-packed from double to single.
  function automatic logic [31:0] ref_x2f(input logic [21:0] x);
    int          xi;
    real         v;
    logic [63:0] d;
    if (x == 22'h0) return 32'h0;
    xi = $signed(x);
    v  = real'(xi) / 1048576.0;
    d  = $realtobits(v);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Drive one cycle of inputs, then check outputs 1 time unit after the capturing edge.
  task automatic step(input logic v, input logic [31:0] f, input logic [21:0] x);
    in_valid = v;
    float_in = f;
    fixed_in = x;
    @(posedge clk);
    #1;
    if (v) begin
      exp_fixed = ref_f2x(f);
      exp_float = ref_x2f(x);
    end
    check("out_valid", 32'(out_valid), 32'(v));
    check("fixed_out", 32'(fixed_out), 32'(exp_fixed));
    check("float_out", float_out, exp_float);
  endtask

  function automatic logic [31:0] rand_float();
    logic [7:0] e;
    int sel = $urandom_range(0, 19);
    if (sel == 0)      e = 8'd0;
    else if (sel == 1) e = 8'd255;
    else               e = 8'($urandom_range(100, 135));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  logic [31:0] f2x_vec [10] = '{32'h3F800000, 32'h3F490FDB, 32'hBF800000, 32'h00000000,
                                32'h40400000, 32'hC0000000, 32'hC0400000, 32'h7F800000,
                                32'h7FC00000, 32'h33800000};
  logic [21:0] f2x_exp [10] = '{22'h100000, 22'h0C90FD, 22'h300000, 22'h000000,
                                22'h1FFFFF, 22'h200000, 22'h200000, 22'h1FFFFF,
                                22'h000000, 22'h000000};
  logic [21:0] x2f_vec [5]  = '{22'h100000, 22'h09B74E, 22'h200000, 22'h000001, 22'h1FFFFF};
  logic [31:0] x2f_exp [5]  = '{32'h3F800000, 32'h3F1B74E0, 32'hC0000000, 32'h35800000,
                                32'h3FFFFFF8};

  initial begin
    logic [21:0] cur;
    logic [21:0] prev;
    logic [31:0] fb;
    int          n_valid_hi;

    // Reset held with live inputs: outputs must stay cleared.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    float_in = 32'h3F800000;
    fixed_in = 22'h100000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_fixed", 32'(fixed_out), 32'h0);
    check("rst_float", float_out, 32'h0);
    rst_n = 1'b1;

    // First cycle after release with no input: nothing valid, values still zero.
    step(1'b0, 32'h3F800000, 22'h100000);
    step(1'b1, 32'h3F800000, 22'h100000);

    // Directed float -> fixed, checked against literal expected codes.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, f2x_vec[i], 22'h0);
      check("dir_f2x", 32'(fixed_out), 32'(f2x_exp[i]));
    end

    // Directed fixed -> float.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h0, x2f_vec[i]);
      check("dir_x2f", float_out, x2f_exp[i]);
    end

    // Hold: in_valid low keeps the last results.
    step(1'b1, 32'hBF800000, 22'h09B74E);
    step(1'b0, 32'h3F800000, 22'h000001);
    check("hold_fixed", 32'(fixed_out), 32'h300000);
    check("hold_float", float_out, 32'h3F1B74E0);

    // Mid-stream asynchronous reset discards results immediately.
    step(1'b1, 32'h3F800000, 22'h100000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'h0);
    check("async_fixed", 32'(fixed_out), 32'h0);
    check("async_float", float_out, 32'h0);
    @(posedge clk);
    #1;
    check("async_hold", 32'(fixed_out), 32'h0);
    rst_n     = 1'b1;
    exp_fixed = '0;
    exp_float = '0;
    step(1'b0, 32'h3F800000, 22'h100000);
    step(1'b1, 32'h3F800000, 22'h100000);
    check("post_rst_fixed", 32'(fixed_out), 32'h100000);

    // Randomized mixed stimulus with occasional idle cycles.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 7) != 0), rand_float(), 22'($urandom));
    end

    // Round-trip stream: each float result is fed back into float_in one cycle later.
    n_valid_hi = 0;
    cur = 22'h0;
    step(1'b1, 32'h0, cur);
    for (int i = 1; i < 16000; i++) begin
      prev = cur;
      if (i < 4096)       cur = 22'(i);
      else if (i < 8192)  cur = 22'(22'h1FF000 + (i - 4096));
      else if (i < 10240) cur = 22'(22'h200000 + (i - 8192));
      else                cur = 22'($urandom);
      fb = float_out;
      step(1'b1, fb, cur);
      check("roundtrip", 32'(fixed_out), 32'(prev));
      if (out_valid) n_valid_hi++;
    end
    check("no_bubbles", 32'(n_valid_hi), 32'd15999);

    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fixed_float_converter.md
Name: fixed_float_converter

Overview:
- Bidirectional number-format converter for the CORDIC datapath.
- Forward path turns an IEEE-754 single-precision angle into the 22-bit signed Q2.20 fixed-point format used by the CORDIC stages.
- Reverse path turns a Q2.20 stage result back into IEEE-754 single.
- Both paths are combinational conversions followed by one output register stage, so the block can sit at either end of a pipelined CORDIC.

Parameters:
- FIXED_W, 22, fixed-point word width (1 sign, 1 integer, 20 fraction bits); fixed at 22.
- FRAC_W, 20, number of fraction bits in the fixed word.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies float_in and fixed_in this cycle.
- float_in  input  32  IEEE-754 single to convert to fixed.
- fixed_in  input  22  Q2.20 two's-complement value to convert to float.
- out_valid  output  1  registered copy of in_valid.
- fixed_out  output  22  Q2.20 result of converting float_in.
- float_out  output  32  IEEE-754 result of converting fixed_in.

Behaviour:
- Reset: rst_n low clears out_valid, fixed_out and float_out to 0 immediately, independent of clk.
- Latency: exactly 1 cycle.
  - On a clk rise with in_valid=1, both results are registered and out_valid goes to 1.
  - On a clk rise with in_valid=0, out_valid goes to 0 and fixed_out/float_out hold their previous values.
  - Full throughput: a new input is accepted every cycle. There is no backpressure.
- A reset asserted mid-stream discards the in-flight result. The first valid output after release appears 1 cycle after the first accepted input.
- Float to fixed:
  - Value = (-1)^s × 1.m × 2^(e-127).
  - Fixed magnitude = floor(|value| × 2^20), i.e. truncation toward zero. Negate (two's complement, 22-bit) when s=1.
  - e=0 (zero or denormal) gives 0x000000.
  - NaN (e=255, m≠0) gives 0x000000.
  - Underflow (|value| < 2^-20) gives 0x000000, including negative inputs. Never output -0.
  - Saturation, positive: if value ≥ 2.0 or value = +inf, output 0x1FFFFF.
  - Saturation, negative: if value ≤ -2.0 or value = -inf, output 0x200000. -2.0 is exactly representable.
- Fixed to float:
  - Exact conversion; no rounding is needed because 22 bits fit in 24-bit significand precision.
  - 0x000000 gives 0x00000000 (+0).
  - Sign = fixed_in[21]. Magnitude = |fixed_in|; 0x200000 has magnitude 2^21 and maps to 0xC0000000 (-2.0).
  - p = index of the magnitude's leading one (0..21). Exponent = 127 + p - 20.
  - Mantissa = magnitude shifted left by (23 - p) with the hidden bit removed. Low bits are zero-filled.
- The two paths are independent and both are computed every cycle from the same in_valid.

Test Plan:
- Reset → while rst_n=0, drive in_valid=1 with nonzero inputs: out_valid=0, fixed_out=0, float_out=0 asynchronously. After release, the first output appears 1 cycle after the first accepted input.
- Float to fixed, nominal values:
  - float_in=0x3F800000 (1.0) → fixed_out=0x100000.
  - 0x3F490FDB (π/4) → 0x0C90FD.
  - 0xBF800000 (-1.0) → 0x300000.
  - 0x00000000 → 0x000000.
- Float to fixed, saturation and specials:
  - 0x40400000 (3.0) → 0x1FFFFF.
  - 0xC0000000 (-2.0) → 0x200000.
  - 0xC0400000 (-3.0) → 0x200000.
  - 0x7F800000 (+inf) → 0x1FFFFF.
  - 0x7FC00000 (NaN) → 0x000000.
  - 0x33800000 (2^-24) → 0x000000.
- Fixed to float:
  - fixed_in=0x100000 → float_out=0x3F800000.
  - 0x09B74E → 0x3F1B74E0.
  - 0x200000 → 0xC0000000.
  - 0x000001 → 0x35800000.
  - 0x1FFFFF → 0x3FFFFFF8.
- Round-trip and throughput: stream 0x000000..0x1FFFFF fixed values through fixed to float, feeding each result back into float_in one cycle later → fixed_out equals the original value for all inputs. out_valid stays high for back-to-back in_valid with no bubbles.
